// File: rtl/cpu.sv
// Single-cycle 8-bit CPU: 32-bit PC, 32-bit instructions, 8x8 register file.
// Optional shift opcodes (SLL/SRL) are enabled by defining CPU_SHIFT_OPS_EN.

module cpu_reg_file #(
    parameter int NREGS = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] REGISTER [0:NREGS-1];

    // Reads are combinational, so a same-cycle read of the write target sees the old value.
    assign rs1_data = REGISTER[rs1_addr];
    assign rs2_data = REGISTER[rs2_addr];

    // NOTE: the array is reset because an asynchronous clear of every register is
    // architecturally visible here; this precludes mapping the file onto block RAM.
    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                REGISTER[i] <= '0;
            end
        end else if (wr_en) begin
            REGISTER[wr_addr] <= wr_data;
        end
    end

endmodule

module cpu #(
    parameter int NREGS = 8,
    parameter int DW    = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] PC,
    input  logic [31:0] INSTRUCTION
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [7:0] {
        OP_LOADI = 8'h00,
        OP_MOV   = 8'h01,
        OP_ADD   = 8'h02,
        OP_SUB   = 8'h03,
        OP_AND   = 8'h04,
        OP_OR    = 8'h05,
        OP_J     = 8'h06,
        OP_BEQ   = 8'h07,
        OP_BNE   = 8'h08,
        OP_SLL   = 8'h09,
        OP_SRL   = 8'h0A
    } opcode_t;

    opcode_t       opcode;
    logic [7:0]    offset;
    logic [7:0]    imm;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rs1_idx;
    logic [AW-1:0] rs2_idx;

    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] wr_data;
    logic          wr_en;

    logic [31:0]   pc_plus4;
    logic [31:0]   branch_target;
    logic [31:0]   pc_next;

    assign opcode  = opcode_t'(INSTRUCTION[31:24]);
    assign offset  = INSTRUCTION[23:16];
    assign rd_idx  = INSTRUCTION[16 +: AW];
    assign rs1_idx = INSTRUCTION[8 +: AW];
    assign rs2_idx = INSTRUCTION[0 +: AW];
    assign imm     = INSTRUCTION[7:0];

    cpu_reg_file #(
        .NREGS (NREGS),
        .DW    (DW)
    ) my_reg (
        .CLK      (CLK),
        .RESET    (RESET),
        .rs1_addr (rs1_idx),
        .rs2_addr (rs2_idx),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wr_en),
        .wr_addr  (rd_idx),
        .wr_data  (wr_data)
    );

    // Offset counts instructions, so it is sign-extended and scaled by 4.
    assign pc_plus4      = PC + 32'd4;
    assign branch_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        pc_next = pc_plus4;
        unique case (opcode)
            OP_LOADI: begin wr_en = 1'b1; wr_data = DW'(imm);            end
            OP_MOV:   begin wr_en = 1'b1; wr_data = rs2_data;            end
            OP_ADD:   begin wr_en = 1'b1; wr_data = rs1_data + rs2_data; end
            OP_SUB:   begin wr_en = 1'b1; wr_data = rs1_data - rs2_data; end
            OP_AND:   begin wr_en = 1'b1; wr_data = rs1_data & rs2_data; end
            OP_OR:    begin wr_en = 1'b1; wr_data = rs1_data | rs2_data; end
            OP_J:     pc_next = branch_target;
            OP_BEQ:   if (rs1_data == rs2_data) pc_next = branch_target;
            OP_BNE:   if (rs1_data != rs2_data) pc_next = branch_target;
`ifdef CPU_SHIFT_OPS_EN
            OP_SLL:   begin wr_en = 1'b1; wr_data = rs1_data << imm[2:0]; end
            OP_SRL:   begin wr_en = 1'b1; wr_data = rs1_data >> imm[2:0]; end
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PC <= 32'd0;
        end else begin
            PC <= pc_next;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed testbench for cpu: a behavioural instruction ROM feeds the DUT and
// register state is probed through dut.my_reg.REGISTER.

module tb_cpu;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;

    logic [31:0] imem [0:15];
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [31:0] NOP_WORD = 32'hFF00_0000;

    always #5 CLK = ~CLK;

    assign INSTRUCTION = imem[PC[5:2]];

    cpu dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .INSTRUCTION (INSTRUCTION)
    );

    function automatic logic [31:0] reg_val(input int idx);
        return {24'd0, dut.my_reg.REGISTER[idx]};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, PC, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_r%0d", tag, i), reg_val(i), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = NOP_WORD;
        imem[0]  = 32'h00_01_00_05; // LOADI R1,5
        imem[1]  = 32'h00_02_00_09; // LOADI R2,9
        imem[2]  = 32'h08_01_01_02; // BNE +1,R1,R2 (taken)
        imem[3]  = 32'h02_03_01_01; // ADD R3,R1,R1 (skipped)
        imem[4]  = 32'h02_03_02_02; // ADD R3,R2,R2
        imem[5]  = 32'h07_01_01_02; // BEQ +1,R1,R2 (not taken)
        imem[6]  = 32'h00_04_00_07; // LOADI R4,7
        imem[7]  = 32'h00_05_00_08; // LOADI R5,8
        imem[8]  = 32'h07_01_02_02; // BEQ +1,R2,R2 (taken)
        imem[9]  = 32'h00_06_00_55; // LOADI R6,0x55 (skipped)
        imem[10] = 32'h3F_07_01_01; // undefined opcode
        imem[11] = 32'h09_07_01_01; // SLL R7,R1,1 (NOP unless shifts enabled)
        imem[12] = 32'h06_FF_00_00; // J -1 -> self loop

        RESET = 1'b1;
        #5;
        check_all_zero("reset");
        @(negedge CLK);
        RESET = 1'b0;

        step(); check("loadi_pc", PC, 32'd4);  check("loadi_r1", reg_val(1), 32'd5);
        step(); check("loadi2_pc", PC, 32'd8); check("loadi2_r2", reg_val(2), 32'd9);
        check("idle_r0", reg_val(0), 32'd0);
        check("idle_r3", reg_val(3), 32'd0);
        check("idle_r7", reg_val(7), 32'd0);
        step(); check("bne_taken_pc", PC, 32'd16);
        check("bne_no_write_r3", reg_val(3), 32'd0);
        step(); check("add_pc", PC, 32'd20);   check("add_r3", reg_val(3), 32'd18);
        step(); check("beq_nt_pc", PC, 32'd24);
        step(); check("r4", reg_val(4), 32'd7);
        step(); check("r5", reg_val(5), 32'd8); check("r5_pc", PC, 32'd32);
        step(); check("beq_t_pc", PC, 32'd40);
        step(); check("undef_pc", PC, 32'd44);
        check("skip_r6", reg_val(6), 32'd0);
        check("undef_r7", reg_val(7), 32'd0);
        check("undef_r1", reg_val(1), 32'd5);
        step(); check("op09_pc", PC, 32'd48);
`ifdef CPU_SHIFT_OPS_EN
        check("sll_r7", reg_val(7), 32'd10);
`else
        check("op09_nop_r7", reg_val(7), 32'd0);
`endif
        step(); check("j_self_pc", PC, 32'd48);
        step(); check("j_self_pc2", PC, 32'd48);

        // Asynchronous reset between edges, then held across edges.
        #2;
        RESET = 1'b1;
        #1;
        check_all_zero("async_rst");
        step(); step();
        check("rst_hold_pc", PC, 32'd0);
        check("rst_hold_r1", reg_val(1), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        step(); step(); step();
        check("rerun_pc16", PC, 32'd16);
        check("rerun_r2", reg_val(2), 32'd9);
        #2;
        RESET = 1'b1;
        #1;
        check_all_zero("rst_at16");

        // ALU program loaded while reset is held.
        for (int i = 0; i < 16; i++) imem[i] = NOP_WORD;
        imem[0] = 32'h00_01_00_F0; // LOADI R1,0xF0
        imem[1] = 32'h00_02_00_20; // LOADI R2,0x20
        imem[2] = 32'h02_03_01_02; // ADD R3,R1,R2
        imem[3] = 32'h03_04_01_02; // SUB R4,R1,R2
        imem[4] = 32'h03_05_02_01; // SUB R5,R2,R1
        imem[5] = 32'h04_00_01_02; // AND R0,R1,R2
        imem[6] = 32'h05_07_01_02; // OR R7,R1,R2
        imem[7] = 32'h01_06_00_02; // MOV R6,R2
        imem[8] = 32'h02_01_01_01; // ADD R1,R1,R1
        imem[9] = 32'h06_FE_00_00; // J -2
        @(negedge CLK);
        RESET = 1'b0;

        step(); check("alu_r1", reg_val(1), 32'hF0);
        step(); check("alu_r2", reg_val(2), 32'h20);
        step(); check("add_wrap", reg_val(3), 32'h10);
        step(); check("sub_pos", reg_val(4), 32'hD0);
        step(); check("sub_neg", reg_val(5), 32'h30);
        step(); check("and", reg_val(0), 32'h20);
        step(); check("or", reg_val(7), 32'hF0);
        step(); check("mov", reg_val(6), 32'h20); check("mov_pc", PC, 32'd32);
        step(); check("add_self", reg_val(1), 32'hE0); check("add_self_pc", PC, 32'd36);
        step(); check("j_back_pc", PC, 32'd32);
        check("j_no_write_r2", reg_val(2), 32'h20);
        step(); check("loop_r1", reg_val(1), 32'hC0); check("loop_pc", PC, 32'd36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
